// File: rtl/conv_window_fetch.sv
// Output-position counters and 3x3 window loader that answers the conv control FSM strobes.
// Optional feature macro CONV_WINDOW_REUSE_EN: reuse two window columns and fetch only column 2.
module conv_window_fetch #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                addr_gen,
    input  logic                load,
    input  logic [1:0]          mux_sel,
    input  logic                counter_enable,
    output logic                load_done,
    output logic                done,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [3*DATA_W-1:0] win_row,
    output logic [7:0]          out_row,
    output logic [7:0]          out_col
);
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] row_off;
    logic              loaded;
    logic [1:0]        rd_r, rd_c;
    logic              rd_last;
    logic              cap_en;
    logic [1:0]        cap_r, cap_c;
    logic [DATA_W-1:0] win [3][3];
    logic              reuse_mode;
    logic              col_wrap, grid_wrap;
    logic              start_fetch;

    assign col_wrap    = (out_col == 8'(OUT_W - 1));
    assign grid_wrap   = col_wrap && (out_row == 8'(OUT_H - 1));
    assign rd_last     = (rd_r == 2'd2) && (rd_c == 2'd2);
    assign start_fetch = (state == IDLE) && (state_nxt == FETCH);

`ifdef CONV_WINDOW_REUSE_EN
    logic reuse_ok;

    // Reuse is only legal when the previous window sits one column to the left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reuse_ok   <= 1'b0;
            reuse_mode <= 1'b0;
        end else begin
            if (counter_enable && col_wrap)
                reuse_ok <= 1'b0;
            else if (state == DONE)
                reuse_ok <= 1'b1;
            if (addr_gen)
                reuse_mode <= reuse_ok;
        end
    end
`else
    assign reuse_mode = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // addr_gen during an active fetch abandons it; a dropped load does not.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load && !loaded) state_nxt = FETCH;
            FETCH:   if (addr_gen) state_nxt = IDLE;
                     else if (rd_last) state_nxt = WAIT;
            WAIT:    state_nxt = addr_gen ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        row_off = '0;
        case (rd_r)
            2'd1:    row_off = ADDR_W'(IMG_W);
            2'd2:    row_off = ADDR_W'(2 * IMG_W);
            default: row_off = '0;
        endcase
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_addr  = '0;
        load_done = 1'b0;
        if (state == FETCH) begin
            mem_rd   = 1'b1;
            mem_addr = base + row_off + ADDR_W'(rd_c);
        end
        if (state == DONE)
            load_done = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r   <= '0;
            rd_c   <= '0;
            cap_en <= 1'b0;
            cap_r  <= '0;
            cap_c  <= '0;
            base   <= '0;
            loaded <= 1'b0;
        end else begin
            cap_en <= (state == FETCH) && !addr_gen;
            cap_r  <= rd_r;
            cap_c  <= rd_c;
            if (start_fetch) begin
                rd_r <= '0;
                rd_c <= reuse_mode ? 2'd2 : 2'd0;
            end else if (state == FETCH) begin
                if (rd_c == 2'd2) begin
                    rd_r <= rd_r + 2'd1;
                    rd_c <= reuse_mode ? 2'd2 : 2'd0;
                end else begin
                    rd_c <= rd_c + 2'd1;
                end
            end
            if (addr_gen) begin
                base   <= ADDR_W'(out_row) * ADDR_W'(IMG_W) + ADDR_W'(out_col);
                loaded <= 1'b0;
            end else if (state == DONE) begin
                loaded <= 1'b1;
            end
        end
    end

    // Read data arrives one cycle after the strobe, so capture uses the delayed index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (start_fetch && reuse_mode) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
        end else if (cap_en) begin
            win[cap_r][cap_c] <= mem_rdata;
        end
    end

    always_comb begin
        win_row = '0;
        case (mux_sel)
            2'd1:    win_row = {win[0][2], win[0][1], win[0][0]};
            2'd2:    win_row = {win[1][2], win[1][1], win[1][0]};
            2'd3:    win_row = {win[2][2], win[2][1], win[2][0]};
            default: win_row = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row <= '0;
            out_col <= '0;
            done    <= 1'b0;
        end else begin
            if (counter_enable) begin
                if (!col_wrap) begin
                    out_col <= out_col + 8'd1;
                end else begin
                    out_col <= '0;
                    out_row <= grid_wrap ? 8'd0 : out_row + 8'd1;
                end
            end
            if (counter_enable && grid_wrap)
                done <= 1'b1;
            else if (addr_gen)
                done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench for conv_window_fetch on a 5x5 image; read addresses and load_done latency
// are checked by a monitor, window rows and position against a behavioural model.
module tb_conv_window_fetch;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int ADDR_W = 10;
    localparam int OUT_W  = IMG_W - 2;
    localparam int OUT_H  = IMG_H - 2;
    localparam int NPIX   = IMG_W * IMG_H;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                addr_gen = 1'b0;
    logic                load = 1'b0;
    logic [1:0]          mux_sel = 2'd0;
    logic                counter_enable = 1'b0;
    logic                load_done;
    logic                done;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic [3*DATA_W-1:0] win_row;
    logic [7:0]          out_row;
    logic [7:0]          out_col;

    conv_window_fetch #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr_gen(addr_gen), .load(load),
        .mux_sel(mux_sel), .counter_enable(counter_enable),
        .load_done(load_done), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .win_row(win_row), .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [NPIX];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd)
            mem_rdata <= (int'(mem_addr) < NPIX) ? ram[mem_addr] : '0;
    end

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int exp_lat[$];
    int load_start = 0;

    // Behavioural model of position, done flag, window contents and reuse eligibility.
    int                m_row, m_col, m_base;
    bit                m_done, m_reuse_ok, m_reuse_mode;
    logic [DATA_W-1:0] m_win [3][3];

    always @(negedge clk) begin
        int e;
        if (rst_n) begin
            if (mem_rd) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_read addr=%0d expected no read", mem_addr);
                end else begin
                    e = exp_addr.pop_front();
                    if (int'(mem_addr) != e) begin
                        errors++;
                        $display("[TB] FAIL read_addr got=%0d expected=%0d", mem_addr, e);
                    end
                end
            end
            if (load_done) begin
                checks++;
                if (exp_lat.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_load_done got=1 expected=0");
                end else begin
                    e = exp_lat.pop_front();
                    if (cyc - load_start != e) begin
                        errors++;
                        $display("[TB] FAIL load_done_cycle got=%0d expected=%0d", cyc - load_start, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_base = 0;
        m_done = 0; m_reuse_ok = 0; m_reuse_mode = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m_win[r][c] = '0;
    endtask

    task automatic check_position();
        check_output("out_row", 32'(out_row), 32'(m_row));
        check_output("out_col", 32'(out_col), 32'(m_col));
        check_output("done", 32'(done), 32'(m_done));
    endtask

    task automatic check_window();
        logic [3*DATA_W-1:0] e;
        for (int s = 0; s < 4; s++) begin
            mux_sel = 2'(s);
            #1;
            e = (s == 0) ? '0 : {m_win[s-1][2], m_win[s-1][1], m_win[s-1][0]};
            check_output($sformatf("win_row_sel%0d", s), 32'(win_row), 32'(e));
        end
        mux_sel = 2'd0;
        tick();
    endtask

    task automatic pulse_enable();
        int lin;
        counter_enable = 1'b1;
        tick();
        counter_enable = 1'b0;
        if (m_col == OUT_W - 1)
            m_reuse_ok = 0;
        lin = m_row * OUT_W + m_col + 1;
        if (lin == OUT_W * OUT_H) begin
            lin = 0;
            m_done = 1;
        end
        m_row = lin / OUT_W;
        m_col = lin % OUT_W;
    endtask

    task automatic do_addr_gen();
        addr_gen = 1'b1;
        tick();
        addr_gen = 1'b0;
        m_base = m_row * IMG_W + m_col;
        m_done = 0;
`ifdef CONV_WINDOW_REUSE_EN
        m_reuse_mode = m_reuse_ok;
`endif
    endtask

    task automatic apply_stimulus();
        int a;
        int lat;
        bit seen;
        if (m_reuse_mode) begin
            for (int r = 0; r < 3; r++) begin
                a = m_base + r * IMG_W + 2;
                exp_addr.push_back(a);
                m_win[r][0] = m_win[r][1];
                m_win[r][1] = m_win[r][2];
                m_win[r][2] = ram[a];
            end
            lat = 5;
        end else begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    a = m_base + r * IMG_W + c;
                    exp_addr.push_back(a);
                    m_win[r][c] = ram[a];
                end
            lat = 11;
        end
        exp_lat.push_back(lat);
        load = 1'b1;
        load_start = cyc;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (load_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL load_done_timeout got=0 expected=1");
            exp_addr.delete();
            exp_lat.delete();
        end
        // Holding load past load_done must not start another fetch.
        repeat (3) tick();
        load = 1'b0;
`ifdef CONV_WINDOW_REUSE_EN
        if (seen)
            m_reuse_ok = 1;
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NPIX; i++)
            ram[i] = DATA_W'(i);
        model_reset();
        repeat (3) tick();
        check_output("rst_load_done", 32'(load_done), 0);
        check_output("rst_mem_rd", 32'(mem_rd), 0);
        check_output("rst_mem_addr", 32'(mem_addr), 0);
        check_position();
        rst_n = 1'b1;
        tick();
        check_window();

        // Fetch at (0,0) with load held; row 1 must be {7,6,5}.
        apply_stimulus();
        mux_sel = 2'd2;
        #1;
        check_output("row1_at_origin", 32'(win_row), 32'h00070605);
        mux_sel = 2'd0;
        check_window();

        // Three steps lands on (1,0), base 5.
        repeat (3) pulse_enable();
        check_position();
        do_addr_gen();
        apply_stimulus();
        check_window();

        // Walk to the end of the grid twice, checking done at every step.
        for (int i = 0; i < 6; i++) begin
            pulse_enable();
            check_position();
        end
        do_addr_gen();
        check_position();
        for (int i = 0; i < 9; i++) begin
            pulse_enable();
            check_position();
        end
        do_addr_gen();
        check_position();

        // Reset asserted during WAIT of a fetch at (1,1).
        repeat (4) pulse_enable();
        do_addr_gen();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_addr.push_back(m_base + r * IMG_W + c);
        load = 1'b1;
        load_start = cyc;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("wait_rst_load_done", 32'(load_done), 0);
        check_output("wait_rst_mem_rd", 32'(mem_rd), 0);
        check_output("wait_rst_mem_addr", 32'(mem_addr), 0);
        check_position();
        check_output("wait_rst_queue_drained", 32'(exp_addr.size()), 0);
        exp_addr.delete();
        exp_lat.delete();
        load = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_window();

        // addr_gen in FETCH cycle 4 aborts; a later load refetches all nine pixels.
        pulse_enable();
        do_addr_gen();
        for (int k = 0; k < 4; k++)
            exp_addr.push_back(m_base + (k / 3) * IMG_W + (k % 3));
        load = 1'b1;
        load_start = cyc;
        repeat (4) tick();
        addr_gen = 1'b1;
        load = 1'b0;
        tick();
        addr_gen = 1'b0;
        m_base = m_row * IMG_W + m_col;
        m_done = 0;
        repeat (15) tick();
        check_output("abort_load_done", 32'(load_done), 0);
        check_output("abort_mem_rd", 32'(mem_rd), 0);
        check_output("abort_reads_left", 32'(exp_addr.size()), 0);
        apply_stimulus();
        check_window();

        // Step one column right; with reuse only column 2 is fetched.
        pulse_enable();
        do_addr_gen();
        apply_stimulus();
        check_window();

        // Random image contents and random walks over the grid.
        for (int i = 0; i < NPIX; i++)
            ram[i] = DATA_W'($urandom);
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 3)) pulse_enable();
            check_position();
            do_addr_gen();
            apply_stimulus();
            check_window();
        end

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_fetch.md
# conv_window_fetch

Datapath responder to the convolution control FSM. It owns the output-position counters and the 3×3 input window. It answers the FSM's `addr_gen`, `load`, `mux_sel` and `counter_enable` strobes with `load_done` and `done`, fetching the window from a synchronous-read image RAM. It sits between the control FSM and the MAC/accumulator datapath.

## Interface
- `DATA_W`, 8, pixel width
- `IMG_W`, 28, input image width in pixels
- `IMG_H`, 28, input image height in pixels
- `ADDR_W`, 10, RAM address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- Reset `rst_n` is asynchronous, active-low; clock is `clk`.
- `clk` in 1: clock
- `rst_n` in 1: async active-low reset
- `addr_gen` in 1: latch window base address for the current position
- `load` in 1: level request to fetch the window, held until `load_done`
- `mux_sel` in 2: window row select (0 = none, 1..3 = rows 0..2)
- `counter_enable` in 1: advance output position
- `load_done` out 1: one-cycle pulse, window valid
- `done` out 1: sticky, last output position consumed
- `mem_rd` out 1: RAM read strobe
- `mem_addr` out ADDR_W: RAM read address
- `mem_rdata` in DATA_W: RAM data, valid the cycle after `mem_rd`
- `win_row` out 3·DATA_W: selected row, {c2,c1,c0}; zero when `mux_sel`=0
- `out_row` out 8: current output row
- `out_col` out 8: current output column

## Operation
- Output grid is OUT_W = IMG_W−2 by OUT_H = IMG_H−2 (valid convolution, stride 1).
- `addr_gen`: register base = out_row·IMG_W + out_col, clear the `loaded` flag, clear `done`.
- Loader FSM states: IDLE, FETCH, WAIT, DONE.
  - IDLE → FETCH when `load`=1 and `loaded`=0.
  - FETCH issues reads k = 0..8 on consecutive cycles, in row-major order (r = k/3, c = k%3).
    - `mem_rd`=1 and `mem_addr` = base + r·IMG_W + c for each read.
    - Data returned for read k is captured into win[r][c] on the following cycle.
  - After the last read, FETCH → WAIT. WAIT captures the final pixel, then WAIT → DONE.
  - In DONE: `load_done`=1, set `loaded`, then DONE → IDLE.
  - Because `loaded` is set, a `load` still high afterwards does not restart the fetch.
- `addr_gen` asserted in FETCH or WAIT aborts the fetch: FSM goes to IDLE, partial window is discarded.
- A `load` drop mid-fetch is ignored; the fetch completes and `load_done` still pulses.
- `win_row` is combinational from `mux_sel` and the window registers.
- `counter_enable` updates the position:
  - If out_col < OUT_W−1: out_col+1.
  - Else out_col = 0 and out_row+1.
  - At (OUT_H−1, OUT_W−1): both counters wrap to 0 and `done` is set.
- `done` stays high until the next `addr_gen`.
- Address arithmetic is unsigned and must not overflow ADDR_W; the maximum address is IMG_W·IMG_H−1.

## Timing
- Reset values:
  - `load_done`=0, `done`=0, `mem_rd`=0, `mem_addr`=0
  - out_row = out_col = 0, window registers 0, `loaded`=0, FSM in IDLE.
- Full load, with cycle 0 being the first cycle IDLE sees `load`=1:
  - FETCH reads occur in cycles 1–9.
  - WAIT is cycle 10.
  - `load_done` is high in cycle 11 only.
- `win_row` is valid from cycle 11 until the next fetch overwrites it.
- Counters and `done` update on the clock edge that samples `counter_enable`; `done` is visible the next cycle.
- A reset assertion mid-fetch returns the block to reset values immediately.

## Configuration
- `CONV_WINDOW_REUSE_EN` defined:
  - Flag `reuse_ok` is set at `load_done` and cleared by any column wrap, by `done`, or by reset.
  - If `reuse_ok`=1 at `addr_gen`, the next load shifts the window left one column (c0←c1, c1←c2).
  - It then fetches only column 2: reads k = 2, 5, 8.
  - `load_done` lands at cycle 5: reads in cycles 1–3, WAIT in cycle 4.
- `CONV_WINDOW_REUSE_EN` undefined: every load performs all 9 reads.

## Test plan
- IMG_W=IMG_H=5, RAM[i]=i. Position (0,0), `load` held:
  - Expect addresses 0,1,2,5,6,7,10,11,12.
  - `load_done` pulses at cycle 11.
  - `mux_sel`=2 gives `win_row`={7,6,5}.
- Three `counter_enable` pulses from (0,0), then `addr_gen`:
  - Position becomes (1,0), base = 5.
  - Window rows read {7,6,5}, {12,11,10}, {17,16,15}.
- Nine `counter_enable` pulses on the 3×3 output grid:
  - `done` rises after the 9th pulse and the counters read (0,0).
  - `done` clears on the next `addr_gen`.
- `addr_gen` at FETCH cycle 4:
  - FSM returns to IDLE with no `load_done`.
  - A new `load` performs a full 9-read fetch.
- `rst_n` low during WAIT: all outputs return to reset values within the same cycle.
- With `CONV_WINDOW_REUSE_EN`, from (0,0) to (0,1):
  - Only addresses 3, 8, 13 are read.
  - `load_done` pulses at cycle 5.
  - Row 0 reads {3,2,1}.
